// File: rtl/data_mover_mc.sv
// Multi-channel packet-buffer data mover: reads a descriptor's flits into a credit-limited
// skid FIFO, steers the FIFO head onto one of NUM_CH Avalon-ST channels, then frees the slot.
module data_mover_mc #(
  parameter int unsigned DWIDTH     = 512,
  parameter int unsigned EWIDTH     = 6,
  parameter int unsigned AWIDTH     = 12,
  parameter int unsigned LWIDTH     = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SKID_DEPTH = 8,
  parameter int unsigned STATS_W    = 32,
  localparam int unsigned CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        meta_valid,
  output logic                        meta_ready,
  input  logic [AWIDTH-1:0]           meta_addr,
  input  logic [LWIDTH-1:0]           meta_len,
  input  logic [EWIDTH-1:0]           meta_last_empty,
  input  logic [CW-1:0]               meta_ch,
  input  logic                        meta_drop,
  output logic [AWIDTH-1:0]           pkt_buffer_address,
  output logic                        pkt_buffer_read,
  input  logic                        pkt_buffer_readvalid,
  input  logic [DWIDTH-1:0]           pkt_buffer_readdata,
  output logic [NUM_CH-1:0]           out_valid,
  input  logic [NUM_CH-1:0]           out_ready,
  input  logic [NUM_CH-1:0]           out_almost_full,
  output logic [DWIDTH-1:0]           out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [EWIDTH-1:0]           out_empty,
  output logic                        emptylist_valid,
  output logic [AWIDTH-1:0]           emptylist_data,
  input  logic                        emptylist_ready,
  output logic [STATS_W-1:0]          stats_in_meta,
  output logic [STATS_W-1:0]          stats_drop_meta,
  output logic [NUM_CH*STATS_W-1:0]   stats_out_pkt,
  output logic [STATS_W-1:0]          stats_out_flit,
  output logic                        err_spurious
);

  localparam int unsigned PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned NW = $clog2(SKID_DEPTH) + 2;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
    logic [EWIDTH-1:0] empty;
    logic [CW-1:0]     ch;
  } flit_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WAIT = 2'd2, S_FREE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   base_q, base_d, addr_q, addr_d;
  logic [LWIDTH-1:0]   len_q, len_d, issued_q, issued_d, rx_idx_q, rx_idx_d;
  logic [EWIDTH-1:0]   lempty_q, lempty_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic                rd_q, rd_d, meta_ready_q, meta_ready_d, el_valid_q, el_valid_d, err_q;
  logic [NW-1:0]       outst_q, outst_d, cnt_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  flit_t               mem_q [SKID_DEPTH];
  flit_t               head, wr_ent;
  logic [STATS_W-1:0]  in_meta_q, drop_meta_q, out_flit_q;
  logic [STATS_W-1:0]  pkt_cnt_q [NUM_CH];

  logic meta_hs, meta_skip, rv_ok, push, pop, fifo_ne, credit_ok;

  assign meta_hs   = meta_valid && meta_ready_q;
  assign meta_skip = meta_drop || (meta_len == '0);
  assign rv_ok     = pkt_buffer_readvalid && (outst_q != '0);
  assign push      = rv_ok;
  assign head      = mem_q[rd_ptr_q];
  assign fifo_ne   = (cnt_q != '0);
  assign pop       = fifo_ne && out_ready[head.ch];
  // The read on the bus this cycle is already counted against the skid space.
  assign credit_ok = (cnt_q + outst_q + NW'(rd_q)) < NW'(SKID_DEPTH);
  assign outst_d   = outst_q + NW'(rd_q) - NW'(rv_ok);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    lempty_d = lempty_q;
    ch_d     = ch_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    rx_idx_d = push ? (rx_idx_q + LWIDTH'(1)) : rx_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (meta_hs) begin
          base_d   = meta_addr;
          len_d    = meta_len;
          lempty_d = meta_last_empty;
          ch_d     = meta_ch;
          issued_d = '0;
          rx_idx_d = '0;
          if (meta_skip) begin
            state_d = S_FREE;
          end else begin
            state_d = S_READ;
            if (credit_ok && !out_almost_full[meta_ch]) begin
              rd_d     = 1'b1;
              addr_d   = meta_addr;
              issued_d = LWIDTH'(1);
              if (meta_len == LWIDTH'(1)) state_d = S_WAIT;
            end
          end
        end
      end
      S_READ: begin
        if (credit_ok && !out_almost_full[ch_q]) begin
          rd_d     = 1'b1;
          addr_d   = base_q + AWIDTH'(issued_q);
          issued_d = issued_q + LWIDTH'(1);
          if ((issued_q + LWIDTH'(1)) == len_q) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (outst_d == '0) state_d = S_FREE;
      end
      S_FREE: begin
        if (emptylist_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    meta_ready_d = (state_d == S_IDLE);
    el_valid_d   = (state_d == S_FREE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      lempty_q     <= '0;
      ch_q         <= '0;
      issued_q     <= '0;
      rx_idx_q     <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      meta_ready_q <= 1'b1;
      el_valid_q   <= 1'b0;
      outst_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      lempty_q     <= lempty_d;
      ch_q         <= ch_d;
      issued_q     <= issued_d;
      rx_idx_q     <= rx_idx_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      meta_ready_q <= meta_ready_d;
      el_valid_q   <= el_valid_d;
      outst_q      <= outst_d;
      err_q        <= err_q | (pkt_buffer_readvalid && (outst_q == '0));
    end
  end

  // Flit tagging: reads return in order, so the receive index identifies sop/eop.
  always_comb begin
    wr_ent.data  = pkt_buffer_readdata;
    wr_ent.sop   = (rx_idx_q == '0);
    wr_ent.eop   = (rx_idx_q == (len_q - LWIDTH'(1)));
    wr_ent.empty = wr_ent.eop ? lempty_q : '0;
    wr_ent.ch    = ch_q;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_ent;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + NW'(push) - NW'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      in_meta_q   <= '0;
      drop_meta_q <= '0;
      out_flit_q  <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) pkt_cnt_q[c] <= '0;
    end else begin
      in_meta_q   <= in_meta_q + STATS_W'(meta_hs);
      drop_meta_q <= drop_meta_q + STATS_W'(meta_hs && meta_skip);
      out_flit_q  <= out_flit_q + STATS_W'(pop);
      for (int c = 0; c < int'(NUM_CH); c++)
        pkt_cnt_q[c] <= pkt_cnt_q[c] + STATS_W'(pop && head.eop && (head.ch == CW'(c)));
    end
  end

  always_comb begin
    out_valid = '0;
    for (int c = 0; c < int'(NUM_CH); c++) out_valid[c] = fifo_ne && (head.ch == CW'(c));
  end

  genvar g;
  for (g = 0; g < int'(NUM_CH); g++) begin : g_stats
    assign stats_out_pkt[g*STATS_W +: STATS_W] = pkt_cnt_q[g];
  end

  assign meta_ready         = meta_ready_q;
  assign pkt_buffer_read    = rd_q;
  assign pkt_buffer_address = addr_q;
  assign out_data           = head.data;
  assign out_sop            = fifo_ne && head.sop;
  assign out_eop            = fifo_ne && head.eop;
  assign out_empty          = head.empty;
  assign emptylist_valid    = el_valid_q;
  assign emptylist_data     = base_q;
  assign stats_in_meta      = in_meta_q;
  assign stats_drop_meta    = drop_meta_q;
  assign stats_out_flit     = out_flit_q;
  assign err_spurious       = err_q;

endmodule

// File: tb/tb_data_mover_mc.sv
// Directed bench for data_mover_mc with a 2-cycle-latency packet buffer model.
module tb_data_mover_mc;
  localparam int unsigned DW = 512, EW = 6, AW = 12, LW = 8, NC = 2, SD = 8, SW = 32;

  logic Clk = 1'b0;
  logic Rst_n;
  logic meta_valid, meta_ready, meta_drop;
  logic [AW-1:0] meta_addr, pkt_buffer_address, emptylist_data;
  logic [LW-1:0] meta_len;
  logic [EW-1:0] meta_last_empty, out_empty;
  logic [0:0] meta_ch;
  logic pkt_buffer_read;
  logic pkt_buffer_readvalid = 1'b0;
  logic [DW-1:0] pkt_buffer_readdata = '0;
  logic [NC-1:0] out_valid, out_ready, out_almost_full;
  logic [DW-1:0] out_data;
  logic out_sop, out_eop, emptylist_valid, emptylist_ready, err_spurious;
  logic [SW-1:0] stats_in_meta, stats_drop_meta, stats_out_flit;
  logic [NC*SW-1:0] stats_out_pkt;

  data_mover_mc #(.DWIDTH(DW), .EWIDTH(EW), .AWIDTH(AW), .LWIDTH(LW), .NUM_CH(NC),
                  .SKID_DEPTH(SD), .STATS_W(SW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_addr(meta_addr),
    .meta_len(meta_len), .meta_last_empty(meta_last_empty), .meta_ch(meta_ch),
    .meta_drop(meta_drop),
    .pkt_buffer_address(pkt_buffer_address), .pkt_buffer_read(pkt_buffer_read),
    .pkt_buffer_readvalid(pkt_buffer_readvalid), .pkt_buffer_readdata(pkt_buffer_readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_almost_full(out_almost_full),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .emptylist_valid(emptylist_valid), .emptylist_data(emptylist_data),
    .emptylist_ready(emptylist_ready),
    .stats_in_meta(stats_in_meta), .stats_drop_meta(stats_drop_meta),
    .stats_out_pkt(stats_out_pkt), .stats_out_flit(stats_out_flit),
    .err_spurious(err_spurious)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    return {a, 488'd0, ~a};
  endfunction

  // Packet buffer: data for address a appears two cycles after the read strobe.
  logic v1 = 1'b0;
  logic [AW-1:0] a1 = '0;
  always @(posedge Clk) begin
    v1 <= pkt_buffer_read;
    a1 <= pkt_buffer_address;
    pkt_buffer_readvalid <= v1;
    pkt_buffer_readdata  <= exp_data(a1);
  end

  logic [AW-1:0] q_raddr[$];
  int            q_rcyc[$];
  logic [DW-1:0] q_bdata[$];
  logic [NC-1:0] q_bv[$];
  logic          q_bsop[$], q_beop[$];
  logic [EW-1:0] q_bemp[$];
  logic [AW-1:0] q_el[$];
  int rd_total = 0, pop_total = 0, max_occ = 0;

  always @(negedge Clk) begin
    if (pkt_buffer_read) begin
      q_raddr.push_back(pkt_buffer_address);
      q_rcyc.push_back(cyc);
      rd_total = rd_total + 1;
    end
    if ((out_valid & out_ready) != '0) begin
      q_bdata.push_back(out_data);
      q_bv.push_back(out_valid);
      q_bsop.push_back(out_sop);
      q_beop.push_back(out_eop);
      q_bemp.push_back(out_empty);
      pop_total = pop_total + 1;
    end
    if (emptylist_valid && emptylist_ready) q_el.push_back(emptylist_data);
    if (rd_total - pop_total > max_occ) max_occ = rd_total - pop_total;
  end

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_meta(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [EW-1:0] e,
                           input logic c, input logic d, output int t);
    meta_addr = a; meta_len = l; meta_last_empty = e; meta_ch = c; meta_drop = d;
    meta_valid = 1'b1;
    for (int n = 0; n < 300 && !meta_ready; n++) step();
    chk("meta_ready_timeout", meta_ready, 1);
    t = cyc;
    step();
    meta_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string tag);
    for (int n = 0; n < 400 && q_bdata.size() < target; n++) step();
    chk(tag, q_bdata.size() >= target, 1);
  endtask

  task automatic wait_el(input int target, input string tag);
    for (int n = 0; n < 400 && q_el.size() < target; n++) step();
    chk(tag, q_el.size() >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tb, r0, b0, e0;
    logic [AW-1:0] wexp [4];
    Rst_n = 1'b0; meta_valid = 1'b0; meta_addr = '0; meta_len = '0; meta_last_empty = '0;
    meta_ch = '0; meta_drop = 1'b0; out_ready = 2'b11; out_almost_full = 2'b00;
    emptylist_ready = 1'b1;
    repeat (3) step();
    Rst_n = 1'b1;
    step();
    chk("rst_meta_ready", meta_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_read", pkt_buffer_read, 0);
    chk("rst_el_valid", emptylist_valid, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_stats_in", stats_in_meta, 0);
    chk("rst_out_data", out_data, 0);

    // Single packet on channel 1
    r0 = q_raddr.size(); b0 = q_bdata.size(); e0 = q_el.size();
    send_meta(12'h010, 8'd3, 6'd5, 1'b1, 1'b0, t);
    wait_beats(b0 + 3, "t1_beat_timeout");
    wait_el(e0 + 1, "t1_el_timeout");
    step();
    chk("t1_nreads", q_raddr.size() - r0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_raddr", q_raddr[r0+i], 12'h010 + i);
      chk("t1_rcyc", q_rcyc[r0+i], t + 1 + i);
      chk("t1_valid", q_bv[b0+i], 2'b10);
      chk("t1_data", q_bdata[b0+i], exp_data(AW'(12'h010 + i)));
      chk("t1_sop", q_bsop[b0+i], i == 0);
      chk("t1_eop", q_beop[b0+i], i == 2);
      chk("t1_empty", q_bemp[b0+i], (i == 2) ? 5 : 0);
    end
    chk("t1_el", q_el[e0], 12'h010);
    chk("t1_pkt1", stats_out_pkt[2*SW-1:SW], 1);
    chk("t1_pkt0", stats_out_pkt[SW-1:0], 0);
    chk("t1_flit", stats_out_flit, 3);
    chk("t1_in", stats_in_meta, 1);

    // Drop and zero length
    r0 = q_raddr.size(); e0 = q_el.size();
    send_meta(12'h020, 8'd5, 6'd0, 1'b0, 1'b1, t);
    chk("t2_el_valid_t1", emptylist_valid, 1);
    chk("t2_el_data", emptylist_data, 12'h020);
    chk("t2_mready_t1", meta_ready, 0);
    step();
    chk("t2_mready_t2", meta_ready, 1);
    send_meta(12'h030, 8'd0, 6'd0, 1'b0, 1'b0, t);
    wait_el(e0 + 2, "t2_el_timeout");
    step();
    chk("t2_noreads", q_raddr.size() - r0, 0);
    chk("t2_el0", q_el[e0], 12'h020);
    chk("t2_el1", q_el[e0+1], 12'h030);
    chk("t2_drop", stats_drop_meta, 2);
    chk("t2_in", stats_in_meta, 3);

    // Address wrap at the top of the buffer
    wexp[0] = 12'hFFE; wexp[1] = 12'hFFF; wexp[2] = 12'h000; wexp[3] = 12'h001;
    r0 = q_raddr.size(); b0 = q_bdata.size(); e0 = q_el.size();
    send_meta(12'hFFE, 8'd4, 6'd3, 1'b0, 1'b0, t);
    wait_beats(b0 + 4, "t3_beat_timeout");
    wait_el(e0 + 1, "t3_el_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("t3_raddr", q_raddr[r0+i], wexp[i]);
      chk("t3_data", q_bdata[b0+i], exp_data(wexp[i]));
      chk("t3_valid", q_bv[b0+i], 2'b01);
      chk("t3_eop", q_beop[b0+i], i == 3);
    end
    chk("t3_empty", q_bemp[b0+3], 3);

    // Backpressure: almost_full window, then ready low until the skid fills
    r0 = q_raddr.size(); b0 = q_bdata.size(); e0 = q_el.size();
    out_ready = 2'b10;
    send_meta(12'h100, 8'd20, 6'd7, 1'b0, 1'b0, t);
    chk("t4_first_read", pkt_buffer_read, 1);
    out_almost_full = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_af_block", pkt_buffer_read, 0);
    end
    out_almost_full = 2'b00;
    repeat (44) step();
    chk("t4_stall_reads", q_raddr.size() - r0, SD);
    chk("t4_stall_beats", q_bdata.size() - b0, 0);
    chk("t4_stall_valid", out_valid, 2'b01);
    out_ready = 2'b11;
    wait_beats(b0 + 20, "t4_beat_timeout");
    wait_el(e0 + 1, "t4_el_timeout");
    step();
    for (int i = 0; i < 20; i++) begin
      chk("t4_raddr", q_raddr[r0+i], 12'h100 + i);
      chk("t4_data", q_bdata[b0+i], exp_data(AW'(12'h100 + i)));
      chk("t4_sop", q_bsop[b0+i], i == 0);
      chk("t4_eop", q_beop[b0+i], i == 19);
    end
    chk("t4_empty", q_bemp[b0+19], 7);
    chk("t4_nbeats", q_bdata.size() - b0, 20);
    chk("t4_occ", max_occ <= SD, 1);
    chk("t4_pkt0", stats_out_pkt[SW-1:0], 2);
    chk("t4_flit", stats_out_flit, 27);

    // Two packets back to back on different channels
    r0 = q_raddr.size(); b0 = q_bdata.size(); e0 = q_el.size();
    send_meta(12'h200, 8'd4, 6'd1, 1'b0, 1'b0, t);
    send_meta(12'h300, 8'd2, 6'd2, 1'b1, 1'b0, tb);
    wait_beats(b0 + 6, "t5_beat_timeout");
    wait_el(e0 + 2, "t5_el_timeout");
    chk("t5_b_first_cyc", q_rcyc[r0+4], tb + 1);
    chk("t5_b_first_addr", q_raddr[r0+4], 12'h300);
    for (int i = 0; i < 4; i++) begin
      chk("t5_a_valid", q_bv[b0+i], 2'b01);
      chk("t5_a_data", q_bdata[b0+i], exp_data(AW'(12'h200 + i)));
    end
    for (int i = 0; i < 2; i++) begin
      chk("t5_b_valid", q_bv[b0+4+i], 2'b10);
      chk("t5_b_data", q_bdata[b0+4+i], exp_data(AW'(12'h300 + i)));
    end
    chk("t5_a_eop", q_beop[b0+3], 1);
    chk("t5_b_sop", q_bsop[b0+4], 1);
    chk("t5_b_empty", q_bemp[b0+5], 2);
    chk("t5_el0", q_el[e0], 12'h200);
    chk("t5_el1", q_el[e0+1], 12'h300);

    // Reset with reads in flight
    send_meta(12'h400, 8'd10, 6'd0, 1'b0, 1'b0, t);
    step();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    b0 = q_bdata.size(); e0 = q_el.size();
    chk("t6_mready", meta_ready, 1);
    chk("t6_read", pkt_buffer_read, 0);
    chk("t6_addr", pkt_buffer_address, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_sop", out_sop, 0);
    chk("t6_eop", out_eop, 0);
    chk("t6_data", out_data, 0);
    chk("t6_el_valid", emptylist_valid, 0);
    chk("t6_in", stats_in_meta, 0);
    chk("t6_flit", stats_out_flit, 0);
    chk("t6_err0", err_spurious, 0);
    step();
    step();
    chk("t6_err1", err_spurious, 1);
    chk("t6_discard_valid", out_valid, 0);
    chk("t6_discard_beats", q_bdata.size() - b0, 0);
    send_meta(12'h500, 8'd2, 6'd4, 1'b1, 1'b0, t);
    wait_beats(b0 + 2, "t6_beat_timeout");
    wait_el(e0 + 1, "t6_el_timeout");
    step();
    chk("t6_d0", q_bdata[b0], exp_data(12'h500));
    chk("t6_d1", q_bdata[b0+1], exp_data(12'h501));
    chk("t6_v", q_bv[b0+1], 2'b10);
    chk("t6_eop_empty", q_bemp[b0+1], 4);
    chk("t6_el", q_el[e0], 12'h500);
    chk("t6_in2", stats_in_meta, 1);
    chk("t6_flit2", stats_out_flit, 2);
    chk("t6_pkt1", stats_out_pkt[2*SW-1:SW], 1);
    chk("t6_err_sticky", err_spurious, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
